// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: assembles big-endian 16-bit commands from UART receiver bytes.
//
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   rx_rdy, rx_data - receiver byte-valid level and byte (held until cleared)
//   clr_rx_rdy      - registered one-cycle acknowledge of an accepted byte
//   cmd, cmd_rdy    - last complete command {first, second byte} and sticky valid flag
//   clr_cmd_rdy     - consumer acknowledge, clears cmd_rdy and overrun
//   overrun         - sticky: a command completed while cmd_rdy was still set
//   to_err          - one-cycle pulse when a partial frame is dropped on inter-byte timeout
//   chk_err         - one-cycle pulse on checksum mismatch (tied 0 without checksum)
//
// Build option: define UART_CMD_CHKSUM_EN for 3-byte frames {hi, lo, ~(hi+lo)}.
module uart_cmd_framer #(
  parameter int unsigned TIMEOUT_CYCLES = 52080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        overrun,
  output logic        to_err,
  output logic        chk_err
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
`ifdef UART_CMD_CHKSUM_EN
    StWaitChk,
`endif
    StWaitLo
  } state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [7:0]         hi_q, hi_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               cmd_rdy_q, cmd_rdy_d;
  logic               overrun_q, overrun_d;
  logic               clr_rx_rdy_q, clr_rx_rdy_d;
  logic               to_err_q, to_err_d;
  logic               chk_err_q, chk_err_d;
  logic               accept;
  logic               frame_done;
  logic [15:0]        frame_cmd;
`ifdef UART_CMD_CHKSUM_EN
  logic [7:0]         lo_q, lo_d;
  logic [7:0]         chk_sum;
`endif

  // The acknowledge cycle never accepts, so a still-high rx_rdy is not captured twice.
  assign accept = rx_rdy & ~clr_rx_rdy_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hi_d         = hi_q;
    cmd_d        = cmd_q;
    cmd_rdy_d    = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
    overrun_d    = clr_cmd_rdy ? 1'b0 : overrun_q;
    clr_rx_rdy_d = accept;
    to_err_d     = 1'b0;
    chk_err_d    = 1'b0;
    frame_done   = 1'b0;
    frame_cmd    = {hi_q, rx_data};
`ifdef UART_CMD_CHKSUM_EN
    lo_d         = lo_q;
    chk_sum      = ~(hi_q + lo_q);
`endif

    case (state_q)
      StIdle: begin
        if (accept) begin
          hi_d    = rx_data;
          timer_d = TimerLoad;
          state_d = StWaitLo;
        end
      end
      StWaitLo: begin
        if (timer_q != '0) timer_d = timer_q - TimerW'(1);
        if (accept) begin
`ifdef UART_CMD_CHKSUM_EN
          lo_d    = rx_data;
          timer_d = TimerLoad;
          state_d = StWaitChk;
`else
          frame_done = 1'b1;
          state_d    = StIdle;
`endif
        end else if (timer_q == '0) begin
          to_err_d = 1'b1;
          state_d  = StIdle;
        end
      end
`ifdef UART_CMD_CHKSUM_EN
      StWaitChk: begin
        if (timer_q != '0) timer_d = timer_q - TimerW'(1);
        frame_cmd = {hi_q, lo_q};
        if (accept) begin
          if (rx_data == chk_sum) frame_done = 1'b1;
          else                    chk_err_d  = 1'b1;
          state_d = StIdle;
        end else if (timer_q == '0) begin
          to_err_d = 1'b1;
          state_d  = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Completion beats a simultaneous clear; overrun looks at the pre-edge flag.
    if (frame_done) begin
      cmd_d     = frame_cmd;
      cmd_rdy_d = 1'b1;
      if (cmd_rdy_q) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      hi_q         <= '0;
      cmd_q        <= '0;
      cmd_rdy_q    <= 1'b0;
      overrun_q    <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
      to_err_q     <= 1'b0;
      chk_err_q    <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
      lo_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      hi_q         <= hi_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      overrun_q    <= overrun_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      to_err_q     <= to_err_d;
      chk_err_q    <= chk_err_d;
`ifdef UART_CMD_CHKSUM_EN
      lo_q         <= lo_d;
`endif
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign overrun    = overrun_q;
  assign to_err     = to_err_q;
  assign chk_err    = chk_err_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Testbench for uart_cmd_framer: directed scenarios plus randomized traffic, every cycle
// compared against a frame-level reference model that tracks bytes and deadlines.
module tb_uart_cmd_framer;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        overrun;
  logic        to_err;
  logic        chk_err;

  uart_cmd_framer #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .overrun    (overrun),
    .to_err     (to_err),
    .chk_err    (chk_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes held so far in the frame and the last cycle a next byte may land.
  int          cyc;
  int          m_pos;
  int          deadline;
  logic [7:0]  b0, b1;
  logic [15:0] m_cmd;
  bit          m_rdy, m_ovr, m_clr, m_to, m_chk;
  int          to_cnt, chk_cnt;

  task automatic model_reset();
    m_pos = 0; deadline = 0; b0 = 8'h00; b1 = 8'h00;
    m_cmd = 16'h0000; m_rdy = 0; m_ovr = 0; m_clr = 0; m_to = 0; m_chk = 0;
  endtask

  task automatic model_step();
    bit          acc, done, n_rdy, n_ovr;
    logic [15:0] fc;
    logic [7:0]  e;
    acc   = rx_rdy && !m_clr;
    done  = 0;
    fc    = 16'h0000;
    n_rdy = clr_cmd_rdy ? 1'b0 : m_rdy;
    n_ovr = clr_cmd_rdy ? 1'b0 : m_ovr;
    m_to  = 0;
    m_chk = 0;
    if (acc) begin
      if (m_pos == 0) begin
        b0 = rx_data; m_pos = 1; deadline = cyc + T + 1;
      end else if (m_pos == 1) begin
        b1 = rx_data;
`ifdef UART_CMD_CHKSUM_EN
        m_pos = 2; deadline = cyc + T + 1;
`else
        fc = {b0, b1}; done = 1; m_pos = 0;
`endif
      end else begin
        e = b0 + b1;
        e = ~e;
        if (rx_data == e) begin fc = {b0, b1}; done = 1; end
        else m_chk = 1;
        m_pos = 0;
      end
    end else if (m_pos != 0 && cyc == deadline) begin
      m_to = 1; m_pos = 0;
    end
    if (done) begin
      n_ovr = n_ovr | m_rdy;
      n_rdy = 1;
      m_cmd = fc;
    end
    m_rdy = n_rdy; m_ovr = n_ovr; m_clr = acc;
    if (m_to) to_cnt++;
    if (m_chk) chk_cnt++;
    cyc++;
  endtask

  task automatic compare();
    check("clr_rx_rdy", 32'(clr_rx_rdy), 32'(m_clr));
    check("cmd",        32'(cmd),        32'(m_cmd));
    check("cmd_rdy",    32'(cmd_rdy),    32'(m_rdy));
    check("overrun",    32'(overrun),    32'(m_ovr));
    check("to_err",     32'(to_err),     32'(m_to));
    check("chk_err",    32'(chk_err),    32'(m_chk));
  endtask

  // One clock: drive inputs, advance the model, sample outputs 1 time unit after the edge.
  task automatic cycle(input logic rdy, input logic [7:0] d, input logic clr);
    rx_rdy = rdy; rx_data = d; clr_cmd_rdy = clr;
    model_step();
    @(posedge clk); #1;
    compare();
  endtask

  task automatic idle(input int n, input bit rc);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), rc && ($urandom_range(0, 3) == 0));
  endtask

  // Receiver behaviour: rx_rdy stays high through the acknowledge cycle, then drops.
  task automatic send(input logic [7:0] b, input logic c0, input logic c1);
    cycle(1'b1, b, c0);
    cycle(1'b1, b, c1);
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic c_last);
    logic [7:0] s;
    s = hi + lo;
    send(hi, 1'b0, 1'b0);
`ifdef UART_CMD_CHKSUM_EN
    send(lo, 1'b0, 1'b0);
    send(~s, c_last, 1'b0);
`else
    send(lo, c_last, 1'b0);
`endif
  endtask

  initial begin
    int t0;
    logic [7:0] hb, lb, s;
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    cyc = 0; to_cnt = 0; chk_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    rst = 1'b0;

    // Reset asserted mid-frame drops the partial byte without any error pulse.
    send(8'h77, 1'b0, 1'b0);
    idle(2, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    compare();
    @(posedge clk); #1;
    rst = 1'b0;
    t0 = to_cnt;
    send_frame(8'hA5, 8'h3C, 1'b0);
    idle(1, 1'b0);
    check("reset_frame_cmd", 32'(cmd), 32'h0000_A53C);
    check("reset_frame_rdy", 32'(cmd_rdy), 32'h1);
    idle(T + 3, 1'b0);
    check("reset_no_to", 32'(to_cnt - t0), 32'h0);
    cycle(1'b0, 8'h00, 1'b1);

    // Held rx_rdy yields one byte; the lone byte then times out.
    t0 = to_cnt;
    send(8'h12, 1'b0, 1'b0);
    idle(T + 4, 1'b0);
    check("held_one_timeout", 32'(to_cnt - t0), 32'h1);

    // Timeout boundary: nothing for T+1 cycles, then second byte exactly on timer-0 cycle.
    t0 = to_cnt;
    send(8'h55, 1'b0, 1'b0);
    idle(T + 2, 1'b0);
    check("timeout_pulse", 32'(to_cnt - t0), 32'h1);
    check("timeout_cmd", 32'(cmd), 32'h0000_A53C);
    check("timeout_rdy", 32'(cmd_rdy), 32'h0);
    t0 = to_cnt;
    send(8'h55, 1'b0, 1'b0);
    idle(T - 1, 1'b0);
`ifdef UART_CMD_CHKSUM_EN
    send(8'h66, 1'b0, 1'b0);
    idle(T - 1, 1'b0);
    s = 8'h55 + 8'h66;
    send(~s, 1'b0, 1'b0);
`else
    send(8'h66, 1'b0, 1'b0);
`endif
    idle(2, 1'b0);
    check("boundary_cmd", 32'(cmd), 32'h0000_5566);
    check("boundary_no_to", 32'(to_cnt - t0), 32'h0);
    cycle(1'b0, 8'h00, 1'b1);

    // Overrun then clear.
    send_frame(8'h01, 8'h02, 1'b0);
    send_frame(8'h03, 8'h04, 1'b0);
    idle(1, 1'b0);
    check("ovr_cmd", 32'(cmd), 32'h0000_0304);
    check("ovr_flag", 32'(overrun), 32'h1);
    cycle(1'b0, 8'h00, 1'b1);
    check("ovr_clr_rdy", 32'(cmd_rdy), 32'h0);
    check("ovr_clr_ovr", 32'(overrun), 32'h0);

    // Clear on the completion cycle with cmd_rdy previously low: set wins, no overrun.
    send_frame(8'hBE, 8'hEF, 1'b1);
    check("simul_rdy", 32'(cmd_rdy), 32'h1);
    check("simul_ovr", 32'(overrun), 32'h0);
    check("simul_cmd", 32'(cmd), 32'h0000_BEEF);
    cycle(1'b0, 8'h00, 1'b1);

`ifdef UART_CMD_CHKSUM_EN
    send(8'h10, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b0);
    send(8'hCF, 1'b0, 1'b0);
    check("chk_good_cmd", 32'(cmd), 32'h0000_1020);
    cycle(1'b0, 8'h00, 1'b1);
    t0 = chk_cnt;
    send(8'h10, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    check("chk_bad_pulse", 32'(chk_cnt - t0), 32'h1);
    check("chk_bad_cmd", 32'(cmd), 32'h0000_1020);
    check("chk_bad_rdy", 32'(cmd_rdy), 32'h0);
`endif

    // Randomized traffic: gaps straddle the timeout, random clears and checksum errors.
    for (int f = 0; f < 300; f++) begin
      hb = 8'($urandom);
      lb = 8'($urandom);
      idle($urandom_range(0, 4), 1'b1);
      send(hb, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      idle($urandom_range(0, T + 2), 1'b1);
      send(lb, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
`ifdef UART_CMD_CHKSUM_EN
      idle($urandom_range(0, T + 2), 1'b1);
      s = hb + lb;
      s = ~s;
      if ($urandom_range(0, 2) == 0) s = 8'($urandom);
      send(s, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
`endif
    end
    idle(T + 4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_framer.md
# uart_cmd_framer

Byte-to-command framer between the UART receiver and the robot's command processor. Consumes bytes from the receiver's `rdy`/`clr_rdy` handshake and assembles big-endian 16-bit commands. Presents each command to the command processor with a sticky `cmd_rdy` flag. Enforces an inter-byte timeout so that a lost byte cannot misalign later frames, and reports overrun and framing errors.

## Interface
- `TIMEOUT_CYCLES`, default 52080: max clocks allowed between bytes of one frame (about two character times at 2604 clk/bit).
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_rdy`  in  1  receiver byte-valid level; held until cleared.
- `rx_data`  in  8  receiver byte; stable while `rx_rdy`=1.
- `clr_rx_rdy`  out  1  one-cycle registered pulse acknowledging an accepted byte.
- `cmd`  out  16  last complete command, {first byte, second byte}.
- `cmd_rdy`  out  1  sticky: new command available.
- `clr_cmd_rdy`  in  1  consumer acknowledge; clears `cmd_rdy` and `overrun`.
- `overrun`  out  1  sticky: a command completed while `cmd_rdy` was still 1.
- `to_err`  out  1  one-cycle pulse: partial frame discarded on timeout.
- `chk_err`  out  1  one-cycle pulse: checksum mismatch (0 when checksum is compiled out).

## Operation
- **Byte acceptance:** a byte is accepted on a cycle with `rx_rdy`=1 and `clr_rx_rdy`=0. `clr_rx_rdy` is 1 on the next cycle only. The cycle where `rx_rdy`=1 and `clr_rx_rdy`=1 never accepts a byte, which prevents double capture.
- **IDLE:**
  - Accepted byte goes to `hi_byte`.
  - Timer loads `TIMEOUT_CYCLES`.
  - Next state is WAIT_LO.
- **WAIT_LO:**
  - Timer decrements by 1 per cycle.
  - On an accepted byte, `lo_byte` is stored.
  - Without the checksum option, the frame completes and the state goes to IDLE.
  - With the checksum option, the timer reloads and the state goes to WAIT_CHK.
- **WAIT_CHK** (checksum option only):
  - Timer decrements by 1 per cycle.
  - An accepted byte equal to ~(hi_byte + lo_byte) mod 256 completes the frame.
  - Any other byte pulses `chk_err`. `cmd` is unchanged.
  - Both outcomes return to IDLE.
- **Timeout:** in WAIT_LO or WAIT_CHK, if the timer is 0 and no byte is accepted that cycle:
  - `to_err` pulses for one cycle.
  - Partial bytes are discarded.
  - State returns to IDLE.
  - If a byte is accepted on the same cycle the timer reaches 0, the byte wins.
- **Frame complete:** `cmd` <= {hi_byte, lo_byte}, `cmd_rdy` <= 1. If `cmd_rdy` was already 1, `overrun` <= 1 and `cmd` is overwritten with the newest command.
- **`clr_cmd_rdy`:** clears `cmd_rdy` and `overrun`. If a frame completes on the same cycle, the set wins: `cmd_rdy`=1, and `overrun` is set only if `cmd_rdy` was 1 before the edge.
- **Timer width:** $clog2(TIMEOUT_CYCLES+1). The timer saturates at 0 and never wraps.

## Timing
- **Reset values:**
  - state IDLE
  - `cmd`=16'h0000
  - `cmd_rdy`=0, `overrun`=0
  - `clr_rx_rdy`=0
  - `to_err`=0, `chk_err`=0
  - timer=0
- Reset asserted mid-frame discards all partial bytes. No error pulse is generated.
- Acceptance on cycle N gives `clr_rx_rdy`=1 on N+1. The receiver drops `rx_rdy` at N+2.
- `cmd`/`cmd_rdy` update at the edge ending the cycle the final byte is accepted (visible N+1).
- `to_err`/`chk_err` are high for exactly one cycle, aligned with the return to IDLE.
- Minimum frame spacing is 2 cycles per byte. Back-to-back `rx_rdy` is handled with no loss.
- The timer counts only in WAIT_LO/WAIT_CHK. In IDLE there is no timeout, so bytes may be arbitrarily far apart between frames.

## Configuration
- **`UART_CMD_CHKSUM_EN` defined:**
  - 3-byte frame {hi, lo, chk}.
  - WAIT_CHK state is present.
  - `chk_err` is active.
  - Latency counts from acceptance of the chk byte.
- **`UART_CMD_CHKSUM_EN` undefined:**
  - 2-byte frame.
  - No WAIT_CHK state.
  - `chk_err` is tied 0 and the port remains.

## Test plan
- **Reset and idle:** assert `rst` mid-WAIT_LO, release, send 8'hA5, 8'h3C -> `cmd`=16'hA53C, `cmd_rdy`=1 one cycle after second acceptance, no error pulses, one `clr_rx_rdy` pulse per byte.
- **Held `rx_rdy`:** hold `rx_rdy`=1 for 2 cycles with 8'h12 -> exactly one acceptance, one `clr_rx_rdy` pulse.
- **Timeout boundary (`TIMEOUT_CYCLES`=8):**
  - Send 8'h55 then nothing for 9 cycles -> `to_err` one-cycle pulse, `cmd` unchanged, `cmd_rdy`=0.
  - Repeat with the second byte arriving exactly on the timer-0 cycle -> accepted, no `to_err`.
- **Overrun:**
  - Two frames 16'h0102 then 16'h0304, no `clr_cmd_rdy` -> `cmd`=16'h0304, `overrun`=1.
  - `clr_cmd_rdy` -> both flags 0 next cycle.
- **Simultaneous set/clear:** `clr_cmd_rdy`=1 on the completion cycle of 16'hBEEF with `cmd_rdy` previously 0 -> `cmd_rdy`=1, `overrun`=0.
- **Checksum (`UART_CMD_CHKSUM_EN`):**
  - Bytes 8'h10, 8'h20, 8'hCF -> `cmd`=16'h1020.
  - Bytes 8'h10, 8'h20, 8'h00 -> `chk_err` pulse, `cmd` unchanged, `cmd_rdy` unchanged.
